// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 3-bit select across a downstream 8:1 mux, waits
// SETTLE cycles on each channel, samples mux_out into a shadow word and
// presents the finished 8-bit word with a valid/ready handshake.
//
// Parameter
//   SETTLE   cycles each select value is held before sampling (1..16)
// Ports
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   start    scan request, honoured only when idle
//   cont     continuous mode, latched when a scan is accepted
//   mux_out  selected mux output
//   sel      select bus to the mux
//   data     assembled scan word, data[i] sampled with sel=i
//   valid    data holds a complete word
//   ready    consumer accepts data when valid && ready
//   busy     high whenever not idle
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | stepping sel and sampling mux_out into the shadow word
// HOLD  | word presented on data, waiting for ready
module mux_scan_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       mux_out,
  output logic [2:0] sel,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  if (SETTLE < 1 || SETTLE > 16) begin : g_bad_settle
    $error("mux_scan_ctrl: SETTLE out of range 1..16");
  end

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt, cnt_d;
  logic [7:0] shadow, shadow_d;
  logic [2:0] sel_d;
  logic [7:0] data_d;
  logic       valid_d;
  logic       mode, mode_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt     <= '0;
      shadow  <= '0;
      sel     <= '0;
      data    <= '0;
      valid   <= 1'b0;
      mode    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt     <= cnt_d;
      shadow  <= shadow_d;
      sel     <= sel_d;
      data    <= data_d;
      valid   <= valid_d;
      mode    <= mode_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt;
    shadow_d = shadow;
    sel_d    = sel;
    data_d   = data;
    valid_d  = valid;
    mode_d   = mode;
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d    = '0;
          cnt_d    = '0;
          shadow_d = '0;
          mode_d   = cont;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (cnt == CNT_LAST) begin
          shadow_d[sel] = mux_out;
          cnt_d         = '0;
          if (sel == 3'd7) begin
            // Last bit comes straight from mux_out; data is only ever
            // written here, so in-flight shadow writes never disturb it.
            data_d  = {mux_out, shadow[6:0]};
            valid_d = 1'b1;
            sel_d   = '0;
            state_d = HOLD;
          end else begin
            sel_d = sel + 3'd1;
          end
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      HOLD: begin
        if (ready) begin
          valid_d = 1'b0;
          if (mode) begin
            // Back-to-back scan starts on the handshake edge itself.
            sel_d   = '0;
            cnt_d   = '0;
            mode_d  = cont;
            state_d = SCAN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (SETTLE=1 and SETTLE=3) share the
// same stimulus; a behavioural model of each is compared every cycle, and
// directed scenarios pin latencies and words to literal values.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] in_v = 8'h00;

  logic       mux_out [2];
  logic [2:0] sel     [2];
  logic [7:0] data    [2];
  logic       valid   [2];
  logic       busy    [2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign mux_out[0] = in_v[sel[0]];
  assign mux_out[1] = in_v[sel[1]];

  mux_scan_ctrl #(.SETTLE(1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .mux_out(mux_out[0]),
    .sel(sel[0]), .data(data[0]), .valid(valid[0]), .ready(ready), .busy(busy[0])
  );

  mux_scan_ctrl #(.SETTLE(3)) dut1 (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .mux_out(mux_out[1]),
    .sel(sel[1]), .data(data[1]), .valid(valid[1]), .ready(ready), .busy(busy[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 scanning (k = cycles into the scan),
  // 2 word presented. Bit i is in[i] on the last settle cycle of channel i.
  int         st      [2] = '{1, 3};
  int         m_phase [2] = '{0, 0};
  int         m_k     [2] = '{0, 0};
  logic [7:0] m_bits  [2] = '{8'h00, 8'h00};
  logic [7:0] m_data  [2] = '{8'h00, 8'h00};
  logic       m_valid [2] = '{1'b0, 1'b0};
  logic       m_mode  [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      int s;
      s = st[j];
      if (rst) begin
        m_phase[j] = 0; m_k[j] = 0; m_bits[j] = 8'h00;
        m_data[j] = 8'h00; m_valid[j] = 1'b0; m_mode[j] = 1'b0;
      end else begin
        case (m_phase[j])
          0: if (start) begin
            m_phase[j] = 1; m_k[j] = 0; m_mode[j] = cont;
          end
          1: begin
            if (m_k[j] % s == s - 1) m_bits[j][m_k[j] / s] = in_v[m_k[j] / s];
            if (m_k[j] == 8 * s - 1) begin
              m_data[j] = m_bits[j]; m_valid[j] = 1'b1; m_phase[j] = 2; m_k[j] = 0;
            end else begin
              m_k[j] = m_k[j] + 1;
            end
          end
          default: if (ready) begin
            m_valid[j] = 1'b0;
            if (m_mode[j]) begin
              m_phase[j] = 1; m_k[j] = 0; m_mode[j] = cont;
            end else begin
              m_phase[j] = 0;
            end
          end
        endcase
      end
    end
    #1;
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("model_sel%0d", j), 32'(sel[j]),
          (m_phase[j] == 1) ? 32'(m_k[j] / st[j]) : 32'd0);
      chk($sformatf("model_data%0d", j), 32'(data[j]), 32'(m_data[j]));
      chk($sformatf("model_valid%0d", j), 32'(valid[j]), 32'(m_valid[j]));
      chk($sformatf("model_busy%0d", j), 32'(busy[j]), 32'(m_phase[j] != 0));
    end
  end

  int         lat [2];
  logic [7:0] w   [2];

  // Pulses start, then records for each instance the edges from acceptance
  // to the first valid and the word seen then.
  task automatic scan_once(input logic [7:0] v, input logic rdy, input logic spam);
    int n;
    in_v = v; ready = rdy;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
    lat[0] = -1; lat[1] = -1; w[0] = 8'h00; w[1] = 8'h00;
    n = 0;
    while ((lat[0] < 0 || lat[1] < 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
      for (int j = 0; j < 2; j++)
        if (valid[j] && lat[j] < 0) begin lat[j] = n; w[j] = data[j]; end
      if (spam) start = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    ready = 1'b1; n = 0;
    while ((busy[0] || busy[1]) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_in_budget", 32'(n < 300), 32'd1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sel", 32'(sel[0]), 32'd0);
    chk("reset_data", 32'(data[0]), 32'd0);
    chk("reset_valid", 32'(valid[0]), 32'd0);
    chk("reset_busy", 32'(busy[0]), 32'd0);
    @(negedge clk); rst = 1'b0;

    // a) single scan, ready high
    scan_once(8'hA5, 1'b1, 1'b0);
    chk("a_lat", 32'(lat[0]), 32'd8);
    chk("a_word", 32'(w[0]), 32'hA5);
    chk("a_idle", 32'(busy[0]), 32'd0);
    drain();

    // b) consumer stalls, word must hold
    scan_once(8'h3C, 1'b0, 1'b0);
    chk("b_lat", 32'(lat[1]), 32'd24);
    chk("b_word", 32'(w[1]), 32'h3C);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("b_hold_valid", 32'(valid[1]), 32'd1);
      chk("b_hold_data", 32'(data[1]), 32'h3C);
    end
    ready = 1'b1;
    @(posedge clk); #1;
    chk("b_valid_drop", 32'(valid[1]), 32'd0);
    drain();

    // c) continuous mode, two back-to-back words
    ready = 1'b0; cont = 1'b1; in_v = 8'h0F;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (!valid[0] && n < 50) begin @(posedge clk); #1; n++; end
    chk("c_lat1", 32'(n), 32'd8);
    chk("c_word1", 32'(data[0]), 32'h0F);
    in_v = 8'hF0; cont = 1'b0; ready = 1'b1;
    @(posedge clk); #1;
    chk("c_no_dead_busy", 32'(busy[0]), 32'd1);
    chk("c_valid_drop", 32'(valid[0]), 32'd0);
    n = 0;
    while (!valid[0] && n < 50) begin @(posedge clk); #1; n++; end
    chk("c_lat2", 32'(n), 32'd8);
    chk("c_word2", 32'(data[0]), 32'hF0);
    @(posedge clk); #1;
    chk("c_end_idle", 32'(busy[0]), 32'd0);
    drain();

    // d) reset mid-scan, then a clean scan
    ready = 1'b1; in_v = 8'h00;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (sel[0] != 3'd4 && n < 50) begin @(posedge clk); #1; n++; end
    chk("d_reach_sel4", 32'(sel[0]), 32'd4);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("d_rst_sel", 32'(sel[0]), 32'd0);
    chk("d_rst_data", 32'(data[0]), 32'd0);
    chk("d_rst_valid", 32'(valid[0]), 32'd0);
    chk("d_rst_busy", 32'(busy[0]), 32'd0);
    chk("d_rst_busy1", 32'(busy[1]), 32'd0);
    rst = 1'b0;
    scan_once(8'hFF, 1'b1, 1'b0);
    chk("d_lat", 32'(lat[0]), 32'd8);
    chk("d_word", 32'(w[0]), 32'hFF);
    chk("d_word1", 32'(w[1]), 32'hFF);
    drain();

    // e) start spammed during SCAN and HOLD
    scan_once(8'h96, 1'b0, 1'b1);
    chk("e_lat0", 32'(lat[0]), 32'd8);
    chk("e_lat1", 32'(lat[1]), 32'd24);
    chk("e_word0", 32'(w[0]), 32'h96);
    ready = 1'b1;
    @(posedge clk); #1;
    chk("e_single_word", 32'(busy[0]), 32'd0);
    drain();

    // f) reset and start on the same edge
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("f_busy", 32'(busy[0]), 32'd0);
    chk("f_valid", 32'(valid[0]), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("f_still_idle", 32'(busy[0]), 32'd0);

    // randomized traffic against the model
    repeat (3000) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 3) == 0);
      cont  = 1'($urandom_range(0, 1));
      ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) in_v = 8'($urandom);
    end
    @(negedge clk); rst = 1'b0; start = 1'b0; cont = 1'b0;
    drain();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
